// File: rtl/mem_port_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter_if
//   External memory bus as seen by the port arbiter.
//   master : the arbiter (drives request/address/data, returns error pulse)
//   slave  : the memory (returns ack and read data)
//   Signals:
//     bus_req   request, held until ack or timeout
//     bus_we    write enable for the current request
//     bus_addr  address for the current request
//     bus_wdata write data for the current request
//     bus_ack   completion; bus_rdata is valid in the same cycle
//     bus_rdata read data
//     bus_err   one-cycle pulse after a transaction timed out
// ----------------------------------------------------------------------------
interface mem_port_arbiter_if;
   logic        bus_req;
   logic        bus_we;
   logic [31:0] bus_addr;
   logic [31:0] bus_wdata;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic        bus_err;

   modport master (
      output bus_req, bus_we, bus_addr, bus_wdata, bus_err,
      input  bus_ack, bus_rdata
   );

   modport slave (
      input  bus_req, bus_we, bus_addr, bus_wdata, bus_err,
      output bus_ack, bus_rdata
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one memory bus between the instruction-fetch port and the MEM-stage
//   data port. While either access is outstanding a global stall holds the
//   whole pipeline. Data accesses win over fetches (the MEM-stage access is the
//   older instruction). A wait counter aborts a transaction that gets no ack
//   within TIMEOUT bus cycles; the aborted read returns zero and bus_err pulses.
//
//   Parameters:
//     TIMEOUT         bus_req cycles allowed without bus_ack before abort (>=1)
//     STALL_CNT_INIT  reset value of the stall counter (normally 0)
//   Ports:
//     clk, rst_n      clock, asynchronous active-low reset
//     inst_ren/addr   fetch request and address; inst_data registered result
//     mem_ren/wen     data read / write request (write wins if both)
//     mem_addr/dout   data address and write data; mem_din registered result
//     stall           combinational hold for every pipeline stage
//     stall_cnt       wrapping count of cycles with stall = 1
//     bus             memory bus (master side)
// ----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT        = 255,
   parameter logic [31:0] STALL_CNT_INIT = 32'h0000_0000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  inst_ren,
   input  logic [31:0]           inst_addr,
   output logic [31:0]           inst_data,
   input  logic                  mem_ren,
   input  logic                  mem_wen,
   input  logic [31:0]           mem_addr,
   input  logic [31:0]           mem_dout,
   output logic [31:0]           mem_din,
   output logic                  stall,
   output logic [31:0]           stall_cnt,
   mem_port_arbiter_if.master    bus
);

   localparam int unsigned CW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
   // Value the wait counter holds during the last allowed bus_req cycle.
   localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DATA = 2'd1,
      INST = 2'd2
   } state_t;

   state_t          state_reg;
   logic            bus_req_reg;
   logic            bus_we_reg;
   logic [31:0]     bus_addr_reg;
   logic [31:0]     bus_wdata_reg;
   logic            bus_err_reg;
   logic [31:0]     inst_data_reg;
   logic [31:0]     mem_din_reg;
   logic [31:0]     stall_cnt_reg;
   logic            inst_done_reg;
   logic            data_done_reg;
   logic [CW-1:0]   wait_cnt_reg;
   // Set when the request that started the current bus transaction went away
   // (flush) or the pipeline advanced under it. Its result is still captured,
   // but it must not mark a later request with the same port as done.
   logic            stale_reg;

   logic dreq;
   logic stall_int;
   logic busy;
   logic origin_req;
   logic timeout_hit;
   logic finish;
   logic complete_ok;

   always_comb begin
      dreq        = mem_ren | mem_wen;
      stall_int   = (inst_ren & ~inst_done_reg) | (dreq & ~data_done_reg);
      busy        = (state_reg != IDLE);
      origin_req  = (state_reg == DATA) ? dreq : inst_ren;
      // Ack on the last allowed cycle wins over the timeout.
      timeout_hit = busy & ~bus.bus_ack & (wait_cnt_reg == TO_LAST);
      finish      = busy & (bus.bus_ack | timeout_hit);
      complete_ok = finish & origin_req & ~stale_reg;
   end

   assign stall         = stall_int;
   assign stall_cnt     = stall_cnt_reg;
   assign inst_data     = inst_data_reg;
   assign mem_din       = mem_din_reg;
   assign bus.bus_req   = bus_req_reg;
   assign bus.bus_we    = bus_we_reg;
   assign bus.bus_addr  = bus_addr_reg;
   assign bus.bus_wdata = bus_wdata_reg;
   assign bus.bus_err   = bus_err_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         bus_req_reg   <= 1'b0;
         bus_we_reg    <= 1'b0;
         bus_addr_reg  <= 32'h0000_0000;
         bus_wdata_reg <= 32'h0000_0000;
         bus_err_reg   <= 1'b0;
         inst_data_reg <= 32'h0000_0000;
         mem_din_reg   <= 32'h0000_0000;
         stall_cnt_reg <= STALL_CNT_INIT;
         inst_done_reg <= 1'b0;
         data_done_reg <= 1'b0;
         wait_cnt_reg  <= '0;
         stale_reg     <= 1'b0;
      end else begin
         bus_err_reg <= timeout_hit;

         if (stall_int) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
         end

         // Done flags: cleared when the pipeline advances or the request
         // drops; set only by a completion that still belongs to the request.
         if (!stall_int) begin
            inst_done_reg <= 1'b0;
            data_done_reg <= 1'b0;
         end else begin
            if (!inst_ren) begin
               inst_done_reg <= 1'b0;
            end else if (complete_ok && (state_reg == INST)) begin
               inst_done_reg <= 1'b1;
            end
            if (!dreq) begin
               data_done_reg <= 1'b0;
            end else if (complete_ok && (state_reg == DATA)) begin
               data_done_reg <= 1'b1;
            end
         end

         case (state_reg)
            IDLE: begin
               if (dreq && !data_done_reg) begin
                  state_reg     <= DATA;
                  bus_req_reg   <= 1'b1;
                  bus_we_reg    <= mem_wen;
                  bus_addr_reg  <= mem_addr;
                  bus_wdata_reg <= mem_dout;
                  wait_cnt_reg  <= '0;
                  stale_reg     <= 1'b0;
               end else if (inst_ren && !inst_done_reg) begin
                  state_reg     <= INST;
                  bus_req_reg   <= 1'b1;
                  bus_we_reg    <= 1'b0;
                  bus_addr_reg  <= inst_addr;
                  wait_cnt_reg  <= '0;
                  stale_reg     <= 1'b0;
               end
            end

            DATA, INST: begin
               if (finish) begin
                  state_reg   <= IDLE;
                  bus_req_reg <= 1'b0;
                  if (state_reg == INST) begin
                     inst_data_reg <= bus.bus_ack ? bus.bus_rdata : 32'h0000_0000;
                  end else if (!bus_we_reg) begin
                     mem_din_reg <= bus.bus_ack ? bus.bus_rdata : 32'h0000_0000;
                  end
               end else begin
                  wait_cnt_reg <= wait_cnt_reg + CW'(1);
                  if (!origin_req || !stall_int) begin
                     stale_reg <= 1'b1;
                  end
               end
            end

            default: begin
               state_reg   <= IDLE;
               bus_req_reg <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Table of directed accesses, a hand-written flush and reset sequence, and
//   randomized accesses checked against a transaction-level model. A second
//   instance with a preloaded stall counter shares all stimulus so that the
//   counter wrap can be observed.
// ----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int          TO   = 4;
   localparam logic [31:0] INIT = 32'hFFFF_FFF0;

   typedef struct {
      bit          ir;
      logic [31:0] ia;
      bit          mr;
      bit          mw;
      logic [31:0] ma;
      logic [31:0] md;
      int          lat0;      // extra wait cycles, first bus transaction
      int          lat1;      // extra wait cycles, second bus transaction
      int          exp_stall;
      int          exp_nbus;
      logic [31:0] exp_addr0;
      bit          exp_we0;
      int          exp_err;
      logic [31:0] exp_inst;
      logic [31:0] exp_din;
   } vec_t;

   logic        clk;
   logic        rst_n;
   logic        inst_ren;
   logic [31:0] inst_addr;
   logic [31:0] inst_data;
   logic        mem_ren;
   logic        mem_wen;
   logic [31:0] mem_addr;
   logic [31:0] mem_dout;
   logic [31:0] mem_din;
   logic        stall;
   logic [31:0] stall_cnt;
   logic [31:0] inst_data2;
   logic [31:0] mem_din2;
   logic        stall2;
   logic [31:0] stall_cnt2;

   mem_port_arbiter_if bif ();
   mem_port_arbiter_if bif2 ();

   assign bif2.bus_ack   = bif.bus_ack;
   assign bif2.bus_rdata = bif.bus_rdata;

   mem_port_arbiter #(.TIMEOUT(TO)) dut (
      .clk(clk), .rst_n(rst_n),
      .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din),
      .stall(stall), .stall_cnt(stall_cnt), .bus(bif)
   );

   mem_port_arbiter #(.TIMEOUT(TO), .STALL_CNT_INIT(INIT)) dut_wrap (
      .clk(clk), .rst_n(rst_n),
      .inst_ren(inst_ren), .inst_addr(inst_addr), .inst_data(inst_data2),
      .mem_ren(mem_ren), .mem_wen(mem_wen), .mem_addr(mem_addr),
      .mem_dout(mem_dout), .mem_din(mem_din2),
      .stall(stall2), .stall_cnt(stall_cnt2), .bus(bif2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] exp_total = 32'h0;
   logic [31:0] m_inst = 32'h0;
   logic [31:0] m_din  = 32'h0;
   bit          spurious_ack = 1'b0;
   vec_t        tbl [8];
   vec_t        v;

   // Memory contents: every address reads back a value derived from itself.
   function automatic logic [31:0] rd_pattern(input logic [31:0] a);
      return a ^ 32'h2008_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Transaction-level expectation: each bus access costs one scheduling cycle
   // plus its bus cycles (ack cycle, or TO cycles on timeout); data goes first.
   function automatic vec_t model(input vec_t vi);
      vec_t r;
      int   k;
      int   lat_i;
      r = vi;
      r.exp_stall = 0; r.exp_nbus = 0; r.exp_err = 0;
      r.exp_addr0 = 32'h0; r.exp_we0 = 1'b0;
      lat_i = vi.lat0;
      if (vi.mr || vi.mw) begin
         k = (vi.lat0 + 1 > TO) ? TO : vi.lat0 + 1;
         r.exp_stall += 1 + k;
         r.exp_nbus   = 1;
         r.exp_addr0  = vi.ma;
         r.exp_we0    = vi.mw;
         if (vi.lat0 >= TO) r.exp_err++;
         if (!vi.mw) m_din = (vi.lat0 >= TO) ? 32'h0 : rd_pattern(vi.ma);
         lat_i = vi.lat1;
      end
      if (vi.ir) begin
         k = (lat_i + 1 > TO) ? TO : lat_i + 1;
         r.exp_stall += 1 + k;
         if (r.exp_nbus == 0) r.exp_addr0 = vi.ia;
         r.exp_nbus++;
         if (lat_i >= TO) r.exp_err++;
         m_inst = (lat_i >= TO) ? 32'h0 : rd_pattern(vi.ia);
      end
      r.exp_inst = m_inst;
      r.exp_din  = m_din;
      return r;
   endfunction

   // Applies one pipeline request (called at posedge+1), plays the memory,
   // runs until stall falls, checks, then lets the pipeline advance.
   task automatic run_vec(input string name, input vec_t vv);
      int          st, nb, ne, age, unstable, lat;
      logic [31:0] a0, d0, cur_a, cur_d;
      logic        w0, cur_w;
      bit          done;
      st = 0; nb = 0; ne = 0; age = 0; unstable = 0; done = 1'b0;
      a0 = 32'h0; d0 = 32'h0; w0 = 1'b0; cur_a = 32'h0; cur_d = 32'h0; cur_w = 1'b0;
      inst_ren = vv.ir; inst_addr = vv.ia;
      mem_ren = vv.mr; mem_wen = vv.mw; mem_addr = vv.ma; mem_dout = vv.md;
      for (int c = 0; c < 60; c++) begin
         if (bif.bus_err) ne++;
         if (bif.bus_req) begin
            age++;
            if (age == 1) begin
               nb++;
               cur_a = bif.bus_addr; cur_w = bif.bus_we; cur_d = bif.bus_wdata;
               if (nb == 1) begin a0 = cur_a; w0 = cur_w; d0 = cur_d; end
            end else if (bif.bus_addr !== cur_a || bif.bus_we !== cur_w ||
                         bif.bus_wdata !== cur_d) begin
               unstable++;
            end
            lat = (nb == 1) ? vv.lat0 : vv.lat1;
            bif.bus_ack   = (age == lat + 1);
            bif.bus_rdata = rd_pattern(bif.bus_addr);
         end else begin
            age = 0;
            bif.bus_ack   = spurious_ack ? ($urandom_range(0, 1) == 1) : 1'b0;
            bif.bus_rdata = $urandom;
         end
         #1;
         if (!stall) begin done = 1'b1; break; end
         st++;
         @(posedge clk); #1;
      end
      if (!done) begin
         n_tests++; n_fail++;
         $display("FAIL %s.no_finish: stall still 1 after 60 cycles", name);
      end
      exp_total += 32'(vv.exp_stall);
      check({name, ".stall_cycles"}, st, vv.exp_stall);
      check({name, ".bus_xfers"}, nb, vv.exp_nbus);
      check({name, ".bus_err_pulses"}, ne, vv.exp_err);
      check({name, ".bus_unstable"}, unstable, 0);
      if (vv.exp_nbus > 0) begin
         check({name, ".first_addr"}, a0, vv.exp_addr0);
         check({name, ".first_we"}, {31'h0, w0}, {31'h0, vv.exp_we0});
         if (vv.exp_we0) check({name, ".first_wdata"}, d0, vv.md);
      end
      check({name, ".inst_data"}, inst_data, vv.exp_inst);
      check({name, ".mem_din"}, mem_din, vv.exp_din);
      check({name, ".stall_cnt"}, stall_cnt, exp_total);
      check({name, ".stall_cnt_wrap"}, stall_cnt2, INIT + exp_total);
      @(posedge clk); #1;
      bif.bus_ack = 1'b0;
   endtask

   initial begin
      // ---------------- reset with a fetch request pending ----------------
      rst_n = 1'b0; inst_ren = 1'b1; inst_addr = 32'h5;
      mem_ren = 1'b0; mem_wen = 1'b0; mem_addr = 32'h0; mem_dout = 32'h0;
      bif.bus_ack = 1'b0; bif.bus_rdata = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.bus_req", {31'h0, bif.bus_req}, 32'h0);
      check("rst.bus_we", {31'h0, bif.bus_we}, 32'h0);
      check("rst.bus_addr", bif.bus_addr, 32'h0);
      check("rst.bus_wdata", bif.bus_wdata, 32'h0);
      check("rst.bus_err", {31'h0, bif.bus_err}, 32'h0);
      check("rst.inst_data", inst_data, 32'h0);
      check("rst.mem_din", mem_din, 32'h0);
      check("rst.stall_cnt", stall_cnt, 32'h0);
      check("rst.stall_cnt_wrap", stall_cnt2, INIT);
      check("rst.stall", {31'h0, stall}, 32'h1);
      rst_n = 1'b1;
      v = '{1'b1, 32'h5, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0,
            2, 1, 32'h5, 1'b0, 0, 32'h2008_0005, 32'h0};
      run_vec("after_reset", v);

      // ---------------- directed table (TIMEOUT = 4) ----------------
      tbl[0] = '{1'b1, 32'h10, 1'b1, 1'b0, 32'h40, 32'h0, 0, 0,
                 4, 2, 32'h40, 1'b0, 0, 32'h2008_0010, 32'h2008_0040};
      tbl[1] = '{1'b0, 32'h0, 1'b0, 1'b1, 32'h8, 32'hA5A5_A5A5, 3, 0,
                 5, 1, 32'h8, 1'b1, 0, 32'h2008_0010, 32'h2008_0040};
      tbl[2] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h100, 32'h0, 9, 0,
                 5, 1, 32'h100, 1'b0, 1, 32'h2008_0010, 32'h0};
      tbl[3] = '{1'b1, 32'h200, 1'b0, 1'b0, 32'h0, 32'h0, 2, 0,
                 4, 1, 32'h200, 1'b0, 0, 32'h2008_0200, 32'h0};
      tbl[4] = '{1'b1, 32'h24, 1'b1, 1'b1, 32'h44, 32'h1234_5678, 1, 0,
                 5, 2, 32'h44, 1'b1, 0, 32'h2008_0024, 32'h0};
      tbl[5] = '{1'b1, 32'h30, 1'b1, 1'b0, 32'h60, 32'h0, 0, 7,
                 7, 2, 32'h60, 1'b0, 1, 32'h0, 32'h2008_0060};
      tbl[6] = '{1'b0, 32'h0, 1'b1, 1'b0, 32'h70, 32'h0, 3, 0,
                 5, 1, 32'h70, 1'b0, 0, 32'h0, 32'h2008_0070};
      tbl[7] = '{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0,
                 0, 0, 32'h0, 1'b0, 0, 32'h0, 32'h2008_0070};
      for (int i = 0; i < 8; i++) begin
         run_vec($sformatf("tbl%0d", i), tbl[i]);
         $display("[TB] tbl%0d ir=%0b mr=%0b mw=%0b stall=%0d", i,
                  tbl[i].ir, tbl[i].mr, tbl[i].mw, tbl[i].exp_stall);
      end
      m_inst = tbl[7].exp_inst;
      m_din  = tbl[7].exp_din;

      // ---------------- flush while a fetch is waiting ----------------
      inst_ren = 1'b1; inst_addr = 32'h300; mem_ren = 1'b0; mem_wen = 1'b0;
      bif.bus_ack = 1'b0;
      #1 check("flush.stall_req", {31'h0, stall}, 32'h1);
      @(posedge clk); #1;
      check("flush.bus_req", {31'h0, bif.bus_req}, 32'h1);
      check("flush.bus_addr", bif.bus_addr, 32'h300);
      inst_ren = 1'b0;
      #1 check("flush.stall_dropped", {31'h0, stall}, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(posedge clk); #1;
         check("flush.bus_req_held", {31'h0, bif.bus_req}, 32'h1);
         check("flush.bus_addr_held", bif.bus_addr, 32'h300);
      end
      bif.bus_ack = 1'b1; bif.bus_rdata = 32'hDEAD_0300;
      @(posedge clk); #1;
      bif.bus_ack = 1'b0;
      check("flush.bus_req_after_ack", {31'h0, bif.bus_req}, 32'h0);
      check("flush.inst_data_captured", inst_data, 32'hDEAD_0300);
      exp_total += 32'd1;
      m_inst = 32'hDEAD_0300;
      $display("[TB] flush sequence at 0x300 done");
      v = '{1'b1, 32'h304, 1'b0, 1'b0, 32'h0, 32'h0, 0, 0,
            0, 0, 32'h0, 1'b0, 0, 32'h0, 32'h0};
      v = model(v);
      run_vec("refetch", v);

      // ---------------- randomized accesses vs model ----------------
      spurious_ack = 1'b1;
      for (int i = 0; i < 40; i++) begin
         v.ir   = ($urandom_range(0, 1) == 1);
         v.mr   = ($urandom_range(0, 1) == 1);
         v.mw   = ($urandom_range(0, 3) == 0);
         v.ia   = {$urandom_range(0, 65535), 16'h0} | {20'h0, 12'($urandom_range(0, 1023) * 4)};
         v.ma   = $urandom & 32'hFFFF_FFFC;
         v.md   = $urandom;
         v.lat0 = $urandom_range(0, 5);
         v.lat1 = $urandom_range(0, 5);
         v = model(v);
         run_vec($sformatf("rnd%0d", i), v);
         $display("[TB] rnd%0d ir=%0b mr=%0b mw=%0b lat=%0d/%0d stall=%0d", i,
                  v.ir, v.mr, v.mw, v.lat0, v.lat1, v.exp_stall);
      end
      spurious_ack = 1'b0;
      check("wrap.happened", {31'h0, (stall_cnt2 < INIT)}, 32'h1);

      // ---------------- reset in the middle of a transaction ----------------
      inst_ren = 1'b1; inst_addr = 32'h500; mem_ren = 1'b0; mem_wen = 1'b0;
      bif.bus_ack = 1'b0;
      @(posedge clk); #1;
      check("midrst.bus_req_before", {31'h0, bif.bus_req}, 32'h1);
      rst_n = 1'b0;
      #1;
      check("midrst.bus_req", {31'h0, bif.bus_req}, 32'h0);
      check("midrst.stall_cnt", stall_cnt, 32'h0);
      check("midrst.stall", {31'h0, stall}, 32'h1);
      inst_ren = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      $display("[TB] mid-transaction reset done");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
